// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM states, PC increment
// and the default reset vector.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, PC-relative branch, or
// pseudo-direct jump into the current 256 MB region.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic [31:0] branch_target_s;
  logic [31:0] jump_addr_s;

  assign pc_plus4        = pc + PC_INC;
  assign branch_target_s = pc_plus4 + (branch_offset << 5'd2);
  assign jump_addr_s     = {pc_plus4[31:28], jump_target, 2'b00};

  // Jump outranks a simultaneous taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_addr_s;
    end else if (branch_taken) begin
      next_pc = branch_target_s;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one memory request per instruction, holds
// the fetched word until downstream consumes it, then advances the PC.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [15:0] imm16,
  output logic        instr_valid,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4
);

  localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_e state_r;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic         valid_r;
  logic         req_r;
  logic [31:0]  next_pc_s;
  logic [31:0]  pc_plus4_s;

  next_pc_calc u_next_pc_calc (
    .pc            (pc_r),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .pc_plus4      (pc_plus4_s),
    .next_pc       (next_pc_s)
  );

  // Fetch FSM; req_r is kept equal to (state_r == FETCH) as a flop of its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= RESET_PC_ALIGNED;
      instr_r <= 32'h0000_0000;
      valid_r <= 1'b0;
      req_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
          req_r   <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_r <= imem_rdata;
            valid_r <= 1'b1;
            req_r   <= 1'b0;
            state_r <= HOLD;
          end else begin
            state_r <= FETCH;
          end
        end
        HOLD: begin
          // Redirect inputs only matter on the consume cycle.
          if (!stall) begin
            pc_r    <= next_pc_s;
            valid_r <= 1'b0;
            req_r   <= 1'b1;
            state_r <= FETCH;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign pc_out      = pc_r;
  assign pc_plus4    = pc_plus4_s;
  assign instr       = instr_r;
  assign imm16       = instr_r[15:0];
  assign instr_valid = valid_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a reactive memory/consumer driver
// pushes expected fetches, a monitor pops and checks them against the DUT.
module tb_instruction_fetch;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_offset = 32'd0;
  logic        jump = 1'b0;
  logic [25:0] jump_target = 26'd0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [15:0] imm16;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    int unsigned due;
  } fetch_item_t;

  fetch_item_t exp_q[$];
  fetch_item_t cur;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  logic [31:0] model_pc = TB_RESET_PC;
  logic        prev_valid = 1'b0;

  instruction_fetch #(.RESET_PC(TB_RESET_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .instr         (instr),
    .imm16         (imm16),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference next-PC, straight from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic br,
                                           input logic [31:0] off, input logic jp,
                                           input logic [25:0] tgt);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
    if (br) return seq + off * 32'd4;
    return seq;
  endfunction

  // Word offset that makes a branch from 'from' land on 'to'.
  function automatic logic [31:0] off_to(input logic [31:0] from, input logic [31:0] to);
    logic [31:0] d;
    d = to - from - 32'd4;
    return {{2{d[31]}}, d[31:2]};
  endfunction

  // One cycle of stimulus, called at a negedge; returns at the next negedge.
  task automatic step(input logic rdy, input logic [31:0] rd, input logic stl, input logic br,
                      input logic [31:0] off, input logic jp, input logic [25:0] tgt);
    fetch_item_t it;
    imem_ready    = rdy;
    imem_rdata    = rd;
    stall         = stl;
    branch_taken  = br;
    branch_offset = off;
    jump          = jp;
    jump_target   = tgt;
    if (imem_req && rdy) begin
      it.pc   = model_pc;
      it.word = rd;
      it.due  = cyc + 32'd1;
      exp_q.push_back(it);
    end
    if (instr_valid && !stl) model_pc = ref_next(model_pc, br, off, jp, tgt);
    @(negedge clk);
  endtask

  task automatic run_fetch(input logic [31:0] rd, input int gap);
    repeat (gap) step(1'b0, $urandom, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) break;
      step(1'b1, rd, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    end
    chk("fetch_done", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic consume(input logic br, input logic [31:0] off, input logic jp, input logic [25:0] tgt);
    step(1'b1, $urandom, 1'b0, br, off, jp, tgt);
  endtask

  // Asserts reset between edges, checks it takes effect at once, then
  // releases just after an edge: one IDLE cycle, then FETCH.
  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_imm16", {16'd0, imm16}, 32'd0);
    chk("rst_pc", pc_out, TB_RESET_PC & 32'hFFFF_FFFC);
    exp_q.delete();
    model_pc = TB_RESET_PC & 32'hFFFF_FFFC;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, TB_RESET_PC & 32'hFFFF_FFFC);
    @(negedge clk);
  endtask

  // Monitor: checks each presented instruction against the scoreboard.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (instr_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got %08h, want no instruction", instr);
        end else begin
          cur = exp_q.pop_front();
          chk("instr", instr, cur.word);
          chk("imm16", {16'd0, imm16}, {16'd0, cur.word[15:0]});
          chk("pc_out", pc_out, cur.pc);
          chk("pc_plus4", pc_plus4, cur.pc + 32'd4);
          chk("latency", cyc, cur.due);
        end
      end else if (instr_valid) begin
        chk("instr_hold", instr, cur.word);
        chk("pc_hold", pc_out, cur.pc);
      end
      if (instr_valid) chk("req_in_hold", {31'd0, imem_req}, 32'd0);
      if (imem_req) chk("imem_addr", imem_addr, model_pc);
      prev_valid = instr_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] saved_pc;
    @(negedge clk);
    apply_reset();

    // Sequential stream with memory always ready.
    for (int i = 0; i < 3; i++) begin
      run_fetch(32'h2008_0005, 0);
      chk("seq_pc", pc_out, 32'(i) * 32'd4);
      chk("seq_imm16", {16'd0, imm16}, 32'h0000_0005);
      consume(1'b0, 32'd0, 1'b0, 26'd0);
    end

    // Reach 0x10 and branch backwards by one word.
    run_fetch($urandom, 0);
    consume(1'b0, 32'd0, 1'b0, 26'd0);
    run_fetch($urandom, 1);
    chk("pc_0x10", pc_out, 32'h0000_0010);
    consume(1'b1, 32'hFFFF_FFFC, 1'b0, 26'd0);
    chk("branch_back", imem_addr, 32'h0000_0004);

    // Jump wins over branch at 0x1000_0040.
    run_fetch($urandom, 0);
    consume(1'b1, off_to(32'h0000_0004, 32'h1000_0040), 1'b0, 26'd0);
    run_fetch($urandom, 2);
    chk("pc_0x10000040", pc_out, 32'h1000_0040);
    consume(1'b1, $urandom, 1'b1, 26'h000_0100);
    chk("jump_prio", imem_addr, 32'h1000_0400);

    // Sequential wrap from the top of the address space.
    run_fetch($urandom, 0);
    consume(1'b1, off_to(32'h1000_0400, 32'hFFFF_FFFC), 1'b0, 26'd0);
    run_fetch($urandom, 0);
    chk("pc_top", pc_out, 32'hFFFF_FFFC);
    chk("pc_plus4_wrap", pc_plus4, 32'h0000_0000);
    consume(1'b0, 32'd0, 1'b0, 26'd0);
    chk("pc_wrap", imem_addr, 32'h0000_0000);

    // Long stall with branch pulses that must be ignored.
    run_fetch($urandom, 1);
    saved_pc = model_pc;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, i[0], $urandom, 1'b0, 26'd0);
    consume(1'b0, 32'd0, 1'b0, 26'd0);
    chk("stall_ignored", imem_addr, saved_pc + 32'd4);

    // Memory wait states, then reset in the middle of the fetch.
    for (int i = 0; i < 3; i++) step(1'b0, $urandom, 1'b0, 1'b1, $urandom, 1'b1, $urandom);
    chk("req_waiting", {31'd0, imem_req}, 32'd1);
    apply_reset();
    run_fetch(32'h2008_0005, 0);
    chk("restart_pc", pc_out, TB_RESET_PC);
    consume(1'b0, 32'd0, 1'b0, 26'd0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           {{16{1'b0}}, 16'($urandom)} ^ ($urandom_range(0, 1) == 1 ? 32'hFFFF_0000 : 32'h0),
           $urandom_range(0, 3) == 0, 26'($urandom));
    end

    repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 26'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, PC loaded at reset; bits [1:0] forced to 0.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: stall  input  1  downstream not ready to consume held instruction.
REQ-005 SHALL have port: branch_taken  input  1  redirect to branch target on consume.
REQ-006 SHALL have port: branch_offset  input  32  sign-extended 16-bit immediate from sign-extend stage.
REQ-007 SHALL have port: jump  input  1  redirect to jump target on consume.
REQ-008 SHALL have port: jump_target  input  26  instr_index field of J-type.
REQ-009 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port: imem_addr  output  32  byte address of fetch (= pc_out).
REQ-011 SHALL have port: imem_rdata  input  32  fetched word, valid with imem_ready.
REQ-012 SHALL have port: imem_ready  input  1  memory completes request this cycle.
REQ-013 SHALL have port: instr  output  32  held instruction word.
REQ-014 SHALL have port: imm16  output  16  instr[15:0], feeds sign-extend stage.
REQ-015 SHALL have port: instr_valid  output  1  instr/imm16 valid.
REQ-016 SHALL have port: pc_out  output  32  address of current instruction.
REQ-017 SHALL have port: pc_plus4  output  32  pc_out + 4, combinational.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD; imem_req = (state == FETCH), registered-state decode only.
REQ-019 SHALL transition IDLE -> FETCH unconditionally after one cycle.
REQ-020 SHALL, in FETCH with imem_ready=1, latch imem_rdata into instr, set instr_valid=1 next cycle, go HOLD; otherwise stay in FETCH with imem_addr stable.
REQ-021 SHALL, in HOLD with stall=0 (consume), load pc <= next_pc, clear instr_valid, go FETCH; with stall=1, hold all state.
REQ-022 SHALL compute next_pc: jump=1 -> {pc_plus4[31:28], jump_target, 2'b00}; else branch_taken=1 -> pc_plus4 + (branch_offset << 2); else pc_plus4.
REQ-023 SHALL give jump priority when jump and branch_taken are both 1.
REQ-024 SHALL sample branch_taken, jump, branch_offset and jump_target only on the consume cycle; ignore them otherwise.
REQ-025 SHALL ignore imem_ready and imem_rdata outside FETCH, and stall outside HOLD.
REQ-026 SHALL use modulo-2^32 arithmetic for all PC math; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-027 SHALL keep instr and imm16 stable while instr_valid=1.
REQ-028 SHALL have latency: imem_ready in cycle N -> instr_valid=1 in cycle N+1; best-case throughput one instruction per 2 cycles.

Reset
REQ-029 SHALL, on rst_n=0, immediately force state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, hence imem_req=0, imm16=0.
REQ-030 SHALL abandon an outstanding fetch when reset asserts mid-FETCH; first request after release is to RESET_PC.
REQ-031 SHALL, after rst_n deassertion, assert imem_req on the second rising edge (IDLE cycle, then FETCH).

Structure
REQ-032 SHALL place state enum (IDLE/FETCH/HOLD), PC_INC=4 and default RESET_PC in shared package cpu_pkg.
REQ-033 SHALL implement next-PC selection/adders in one sub-module next_pc_calc (pure combinational); FSM and registers in instruction_fetch.

Verification
REQ-034 SHALL cover: reset release, imem_ready=1 always, rdata=32'h2008_0005 -> req at 0x0, instr_valid next cycle, imm16=16'h0005, pc_out 0x0,0x4,0x8 sequence.
REQ-035 SHALL cover: pc=0x10, branch_taken=1, branch_offset=32'hFFFF_FFFC on consume -> next imem_addr=0x04.
REQ-036 SHALL cover: pc=0x1000_0040, jump=1, branch_taken=1, jump_target=26'h000_0100 -> next imem_addr=0x1000_0400.
REQ-037 SHALL cover: stall=1 for 5 cycles in HOLD -> instr, pc_out constant, imem_req=0; branch_taken pulses during stall ignored.
REQ-038 SHALL cover: imem_ready low 3 cycles in FETCH -> imem_req, imem_addr stable; then rst_n=0 mid-FETCH -> imem_req=0 same cycle, restart at RESET_PC.
REQ-039 SHALL cover: pc=32'hFFFF_FFFC sequential consume -> next imem_addr=32'h0000_0000.
